// File: rtl/exception_unit_if.sv
// rtl/exception_unit_if.sv - exception sequencer signal bundle
interface exception_unit_if;
    logic        exc_in;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        eret;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        exl;
    logic        busy;

    modport master (
        output exc_in, exc_code, exc_pc, eret,
        input  flush, redirect, redirect_pc, epc, cause, exl, busy
    );

    modport slave (
        input  exc_in, exc_code, exc_pc, eret,
        output flush, redirect, redirect_pc, epc, cause, exl, busy
    );
endinterface

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - exception capture, flush hold, handler/eret PC redirect
module exception_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic             clk,
    input logic             rst_n,
    exception_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        ret_q;
    logic [31:0] epc_q;
    logic [4:0]  code_q;
    logic        nest_q;
    logic        exl_q;
    logic        take_exc;
    logic        take_ret;

    // eret only honoured from IDLE; when both fire with exl set, the return wins
    assign take_exc = (state == IDLE) && bus.exc_in && !exl_q;
    assign take_ret = (state == IDLE) && bus.eret && exl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (take_exc) state_nxt = FLUSH;
            FLUSH:    if (cnt == 4'd0) state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 4'd0;
            ret_q  <= 1'b0;
            epc_q  <= 32'd0;
            code_q <= 5'd0;
            nest_q <= 1'b0;
            exl_q  <= 1'b0;
        end else begin
            ret_q <= take_ret;
            if (take_exc) begin
                epc_q  <= bus.exc_pc;
                code_q <= bus.exc_code;
                exl_q  <= 1'b1;
                cnt    <= CNT_INIT;
            end else if (state == FLUSH && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (take_ret) begin
                exl_q  <= 1'b0;
                nest_q <= 1'b0;
            end else if (bus.exc_in && exl_q) begin
                nest_q <= 1'b1;
            end
        end
    end

    // Outputs decode only registered state, so they are glitch-free after each edge
    always_comb begin
        bus.flush       = (state == FLUSH);
        bus.redirect    = (state == REDIRECT) || ret_q;
        bus.redirect_pc = 32'd0;
        if (state == REDIRECT) bus.redirect_pc = HANDLER_ADDR;
        else if (ret_q)        bus.redirect_pc = epc_q;
        bus.busy        = (state != IDLE);
    end

    assign bus.epc   = epc_q;
    assign bus.cause = {nest_q, 24'd0, code_q, 2'b00};
    assign bus.exl   = exl_q;
endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - vector table plus scoreboard bench for exception_unit
module tb_exception_unit;
    localparam logic [31:0] H  = 32'h8000_0180;
    localparam logic [31:0] P1 = 32'h0040_0010;
    localparam logic [31:0] P2 = 32'h0040_0020;
    localparam logic [31:0] P3 = 32'h0040_0030;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exception_unit_if bus0 ();
    exception_unit_if bus1 ();

    exception_unit #(.HANDLER_ADDR(H), .FLUSH_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    exception_unit #(.HANDLER_ADDR(H), .FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    typedef struct {
        logic        exc_in;
        logic [4:0]  exc_code;
        logic [31:0] exc_pc;
        logic        eret;
        logic        flush;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic        exl;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [4:0] c, input logic [31:0] pc, input logic r,
                       input logic f, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] ep, input logic [31:0] ca, input logic x, input logic b);
        vec_t v;
        v.exc_in = e; v.exc_code = c; v.exc_pc = pc; v.eret = r;
        v.flush = f; v.redirect = rd; v.redirect_pc = rpc;
        v.epc = ep; v.cause = ca; v.exl = x; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check_all0(input string tag, input vec_t e);
        check({tag, ".flush"},       32'(bus0.flush),    32'(e.flush));
        check({tag, ".redirect"},    32'(bus0.redirect), 32'(e.redirect));
        check({tag, ".redirect_pc"}, bus0.redirect_pc,   e.redirect_pc);
        check({tag, ".epc"},         bus0.epc,           e.epc);
        check({tag, ".cause"},       bus0.cause,         e.cause);
        check({tag, ".exl"},         32'(bus0.exl),      32'(e.exl));
        check({tag, ".busy"},        32'(bus0.busy),     32'(e.busy));
    endtask

    initial begin
        vec_t v;
        bus0.exc_in = 0; bus0.exc_code = 0; bus0.exc_pc = 0; bus0.eret = 0;
        bus1.exc_in = 0; bus1.exc_code = 0; bus1.exc_pc = 0; bus1.eret = 0;

        //   exc code pc  eret | flush red rpc epc cause exl busy
        add(0, 0,  0,     0,   0, 0, 0,  0,  0,            0, 0);
        add(0, 0,  0,     1,   0, 0, 0,  0,  0,            0, 0);
        add(1, 12, P1,    0,   1, 0, 0,  P1, 32'h30,       1, 1);
        add(0, 0,  0,     0,   1, 0, 0,  P1, 32'h30,       1, 1);
        add(0, 0,  0,     0,   0, 1, H,  P1, 32'h30,       1, 1);
        add(0, 0,  0,     0,   0, 0, 0,  P1, 32'h30,       1, 0);
        add(0, 0,  0,     1,   0, 1, P1, P1, 32'h30,       0, 0);
        add(0, 0,  0,     0,   0, 0, 0,  P1, 32'h30,       0, 0);
        add(1, 5,  P2,    0,   1, 0, 0,  P2, 32'h14,       1, 1);
        add(1, 7,  32'h999, 0, 1, 0, 0,  P2, 32'h8000_0014, 1, 1);
        add(0, 0,  0,     0,   0, 1, H,  P2, 32'h8000_0014, 1, 1);
        add(0, 0,  0,     1,   0, 0, 0,  P2, 32'h8000_0014, 1, 0);
        add(1, 9,  32'h123, 0, 0, 0, 0,  P2, 32'h8000_0014, 1, 0);
        add(0, 0,  0,     1,   0, 1, P2, P2, 32'h14,       0, 0);
        add(0, 0,  0,     1,   0, 0, 0,  P2, 32'h14,       0, 0);
        add(1, 3,  P3,    1,   1, 0, 0,  P3, 32'h0C,       1, 1);
        add(0, 0,  0,     0,   1, 0, 0,  P3, 32'h0C,       1, 1);
        add(0, 0,  0,     0,   0, 1, H,  P3, 32'h0C,       1, 1);
        add(0, 0,  0,     0,   0, 0, 0,  P3, 32'h0C,       1, 0);
        add(1, 2,  32'h77, 1,  0, 1, P3, P3, 32'h0C,       0, 0);
        add(0, 0,  0,     0,   0, 0, 0,  P3, 32'h0C,       0, 0);

        #12;
        v = '{default: '0};
        check_all0("reset", v);
        check("reset.dut1_busy", 32'(bus1.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus0.exc_in = vecs[i].exc_in; bus0.exc_code = vecs[i].exc_code;
            bus0.exc_pc = vecs[i].exc_pc; bus0.eret = vecs[i].eret;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            v = sb.pop_front();
            check_all0($sformatf("vec%0d", i), v);
        end

        // Reset in the middle of FLUSH aborts the sequence outright
        @(negedge clk);
        bus0.exc_in = 1; bus0.exc_code = 4; bus0.exc_pc = 32'h0040_0040; bus0.eret = 0;
        @(posedge clk); #1;
        check("midrst.flush_before", 32'(bus0.flush), 32'd1);
        @(negedge clk);
        bus0.exc_in = 0;
        #2 rst_n = 1'b0;
        #1;
        v = '{default: '0};
        check_all0("midrst", v);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (bus0.redirect || bus0.flush) seen++;
            end
            check("midrst.no_redirect_10", 32'(seen), 32'd0);
        end

        // FLUSH_CYCLES=1 build: a single flush cycle, then the handler redirect
        @(negedge clk);
        bus1.exc_in = 1; bus1.exc_code = 8; bus1.exc_pc = 32'h0040_0050;
        @(posedge clk); #1;
        check("fc1.flush0", 32'(bus1.flush), 32'd1);
        check("fc1.redir0", 32'(bus1.redirect), 32'd0);
        check("fc1.cause", bus1.cause, 32'h20);
        @(negedge clk);
        bus1.exc_in = 0;
        @(posedge clk); #1;
        check("fc1.flush1", 32'(bus1.flush), 32'd0);
        check("fc1.redir1", 32'(bus1.redirect), 32'd1);
        check("fc1.rpc1", bus1.redirect_pc, H);
        @(posedge clk); #1;
        check("fc1.redir2", 32'(bus1.redirect), 32'd0);
        check("fc1.busy2", 32'(bus1.busy), 32'd0);
        check("fc1.exl2", 32'(bus1.exl), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
